uart_cmd_master: RTL and testbench

//  Host-side initiator for the single-byte UART command protocol served by the board MCU responder.

---
 rtl/uart_cmd_pkg.sv | 50 +++++
 rtl/uart_cmd_master.sv | 200 ++++++++++++++++++++
 tb/tb_uart_cmd_master.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the single-byte UART command protocol initiator:
//   - transaction op encoding (OP_CMD, OP_WR, OP_RD, OP_RSV)
//   - command byte bases understood by the board MCU responder; each base is
//     combined with an index 0-7 in the low three bits (see cmd_byte)
//   - the latched request record and the initiator FSM state encoding
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

  // Transaction types
  localparam logic [1:0] OP_CMD = 2'd0;  // command byte only
  localparam logic [1:0] OP_WR  = 2'd1;  // command byte + data byte
  localparam logic [1:0] OP_RD  = 2'd2;  // command byte, then one response byte
  localparam logic [1:0] OP_RSV = 2'd3;  // reserved, completes with err

  // Command byte bases; low three bits carry the index
  localparam logic [7:0] CMD_CLK_HI = 8'h10;
  localparam logic [7:0] CMD_CLK_LO = 8'h11;
  localparam logic [7:0] CMD_RST_HI = 8'h12;
  localparam logic [7:0] CMD_RST_LO = 8'h13;
  localparam logic [7:0] CMD_PIN_RD = 8'h20;
  localparam logic [7:0] CMD_PIN_WR = 8'h30;
  localparam logic [7:0] CMD_REG_WR = 8'h40;
  localparam logic [7:0] CMD_REG_RD = 8'h50;

  // Builds a command byte from a base and an index 0-7
  function automatic logic [7:0] cmd_byte(input logic [7:0] base, input logic [2:0] idx);
    return {base[7:3], idx};
  endfunction

  // Request captured when a transaction is accepted
  typedef struct packed {
    logic [1:0] op;
    logic [7:0] cmd;
    logic [7:0] wdata;
  } req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_CMD,
    ST_WAIT_CMD,
    ST_SEND_DATA,
    ST_WAIT_DATA,
    ST_GAP,
    ST_WAIT_RESP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/uart_cmd_master.sv
// -----------------------------------------------------------------------------
// uart_cmd_master
// Host-side initiator for the single-byte UART command protocol. One local
// transaction (command byte, optional data byte, optional response byte) is
// turned into bytes on the byte interface of an external UART owned by the
// parent; the response byte is returned on rdata.
//
// Optional feature macro: UART_CMD_MASTER_TIMEOUT_EN
//   defined   : WAIT_RESP gives up after TIMEOUT_CYCLES cycles (done, err=1)
//   undefined : WAIT_RESP waits forever, no timeout counter exists
//
// Parameters
//   GAP_CYCLES      idle cycles inserted after every transmitted byte
//   TIMEOUT_CYCLES  response wait limit (timeout build only)
//
// Ports
//   sys_clk   in      clock, all logic on posedge
//   sys_rst   in      synchronous active-high reset
//   start     in      1-cycle request pulse, taken only while idle
//   op        in  2   OP_CMD / OP_WR / OP_RD / OP_RSV
//   cmd       in  8   command byte
//   wdata     in  8   data byte for OP_WR
//   busy      out     transaction in progress
//   done      out     1-cycle completion pulse
//   err       out     with done: timeout or reserved op
//   rdata     out 8   response byte, held until the next OP_RD completes
//   tx_start  out     1-cycle send pulse to the byte UART
//   tx_data   out 8   byte to send, held while the UART is busy
//   tx_busy   in      byte UART busy, rises the cycle after tx_start
//   rx_valid  in      byte UART receive flag (level); rising edge = new byte
//   rx_data   in  8   received byte
// -----------------------------------------------------------------------------
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] cmd,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rdata,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_valid,
  input  logic [7:0] rx_data
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t           state;
  state_t           gap_next;    // where GAP goes once it has run out
  state_t           byte_next;   // successor of the byte just finished
  req_t             req;
  logic             wait_first;  // tx_busy is not yet valid in the first WAIT cycle
  logic             err_pend;    // err value to present with done
  logic [GAP_W-1:0] gap_cnt;
  logic             rx_valid_q;
  logic             rx_rise;

`ifdef UART_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned RESP_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [RESP_W-1:0] RESP_LAST = RESP_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  logic [RESP_W-1:0] resp_cnt;
`endif

  assign rx_rise = rx_valid & ~rx_valid_q;

  // After the command byte the op decides; after the data byte we are done.
  always_comb begin
    // NOTE: default first so every path assigns byte_next and no latch is inferred.
    byte_next = ST_DONE;
    if (state == ST_WAIT_CMD) begin
      case (req.op)
        OP_WR:   byte_next = ST_SEND_DATA;
        OP_RD:   byte_next = ST_WAIT_RESP;
        default: byte_next = ST_DONE;
      endcase
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      gap_next   <= ST_IDLE;
      req        <= '0;
      wait_first <= 1'b0;
      err_pend   <= 1'b0;
      gap_cnt    <= '0;
      rx_valid_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= 8'h00;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
      resp_cnt   <= '0;
`endif
    end else begin
      rx_valid_q <= rx_valid;
      done       <= 1'b0;
      tx_start   <= 1'b0;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
      // Holding the counter at zero outside WAIT_RESP clears it on entry.
      if (state != ST_WAIT_RESP) resp_cnt <= '0;
`endif

      case (state)
        ST_IDLE: begin
          if (start) begin
            req  <= '{op: op, cmd: cmd, wdata: wdata};
            busy <= 1'b1;
            if (op == OP_RSV) begin
              err_pend <= 1'b1;
              state    <= ST_DONE;
            end else begin
              err_pend <= 1'b0;
              state    <= ST_SEND_CMD;
            end
          end
        end

        ST_SEND_CMD: begin
          if (!tx_busy) begin
            tx_start   <= 1'b1;
            tx_data    <= req.cmd;
            wait_first <= 1'b1;
            state      <= ST_WAIT_CMD;
          end
        end

        ST_SEND_DATA: begin
          if (!tx_busy) begin
            tx_start   <= 1'b1;
            tx_data    <= req.wdata;
            wait_first <= 1'b1;
            state      <= ST_WAIT_DATA;
          end
        end

        ST_WAIT_CMD, ST_WAIT_DATA: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!tx_busy) begin
            if (GAP_CYCLES == 0) begin
              state <= byte_next;
            end else begin
              gap_cnt  <= '0;
              gap_next <= byte_next;
              state    <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= gap_next;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end

        ST_WAIT_RESP: begin
          // An edge coinciding with entry was seen while still in GAP and is lost.
          if (rx_rise) begin
            rdata    <= rx_data;
            err_pend <= 1'b0;
            state    <= ST_DONE;
          end
`ifdef UART_CMD_MASTER_TIMEOUT_EN
          else if (resp_cnt == RESP_LAST) begin
            err_pend <= 1'b1;
            state    <= ST_DONE;
          end else if (resp_cnt != '1) begin
            resp_cnt <= resp_cnt + 1'b1;
          end
`endif
        end

        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          err   <= err_pend;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_master
// Self-checking bench for uart_cmd_master. A byte-UART model and an MCU
// register-file model surround the DUT; each issued transaction pushes its
// expected tx bytes and completion record into queues that an independent
// monitor pops whenever the DUT pulses tx_start or done.
// Define UART_CMD_MASTER_TIMEOUT_EN to also exercise the response timeout.
// -----------------------------------------------------------------------------
module tb_uart_cmd_master;
  import uart_cmd_pkg::*;

  localparam int GAP         = 5;
  localparam int TMO         = 100;
  localparam int BYTE_CYCLES = 10;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       start   = 1'b0;
  logic [1:0] op      = 2'd0;
  logic [7:0] cmd     = 8'h00;
  logic [7:0] wdata   = 8'h00;
  logic       busy, done, err;
  logic [7:0] rdata;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy  = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;

  always #5 sys_clk = ~sys_clk;

  uart_cmd_master #(
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (start),
    .op      (op),
    .cmd     (cmd),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .rdata   (rdata),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .rx_valid(rx_valid),
    .rx_data (rx_data)
  );

  typedef struct {
    logic       err;
    logic [7:0] rdata;
  } exp_done_t;

  exp_done_t  done_q[$];
  logic [7:0] tx_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] reg_mem[8];     // MCU register file
  logic [7:0] model_rdata = 8'h00;
  bit         mon_rst_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Byte UART model: busy from the cycle after tx_start for BYTE_CYCLES cycles
  initial begin
    forever begin
      @(negedge sys_clk);
      if (tx_start === 1'b1) begin
        @(posedge sys_clk);
        #1 tx_busy = 1'b1;
        repeat (BYTE_CYCLES) @(posedge sys_clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  always @(posedge sys_clk) if (sys_rst) mon_rst_seen = 1'b1;

  // Monitor / scoreboard
  initial begin
    logic       busy_prev  = 1'b0;
    bit         armed      = 1'b0;
    bit         sent_valid = 1'b0;
    int         idle       = 0;
    logic [7:0] sent       = 8'h00;
    exp_done_t  e;
    forever begin
      @(negedge sys_clk);
      if (mon_rst_seen) begin
        mon_rst_seen = 1'b0;
        armed        = 1'b0;
        sent_valid   = 1'b0;
        busy_prev    = tx_busy;
        continue;
      end
      if (tx_start) begin
        if (armed) check_range("gap before tx byte", idle, GAP, GAP + 3);
        armed = 1'b0;
        check("tx_busy low at tx_start", tx_busy, 0);
        if (tx_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL tx byte: got unexpected %0h expected none", tx_data);
        end else begin
          check("tx byte", tx_data, tx_q.pop_front());
        end
        sent       = tx_data;
        sent_valid = 1'b1;
      end
      if (done) begin
        if (armed) check_range("gap before done", idle, GAP, 1 << 20);
        armed = 1'b0;
        if (done_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL done: got unexpected done expected none");
        end else begin
          e = done_q.pop_front();
          check("done err", err, e.err);
          check("done rdata", rdata, e.rdata);
        end
      end
      if (busy_prev && !tx_busy && sent_valid) begin
        check("tx_data stable over byte", tx_data, sent);
        sent_valid = 1'b0;
        armed      = 1'b1;
        idle       = 0;
      end else if (armed) begin
        idle++;
      end
      busy_prev = tx_busy;
    end
  end

  task automatic pulse_rx(input logic [7:0] b);
    @(negedge sys_clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge sys_clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    bit ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge sys_clk);
      cycles++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done wait: got no done expected done within 5000 cycles");
    end
  endtask

  task automatic wait_tx_fall();
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge sys_clk);
      if (tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(negedge sys_clk);
        if (!tx_busy) begin
          ok = 1'b1;
          break;
        end
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL tx byte wait: got no complete byte expected one within 500 cycles");
    end
  endtask

  // Issues one transaction; the model records what the monitor must see.
  task automatic issue(input logic [1:0] o, input logic [7:0] c, input logic [7:0] w,
                       input bit answer, input bit stray);
    exp_done_t  e;
    logic [7:0] resp = 8'h00;
    int         cyc;
    if (o == OP_WR && c[7:3] == CMD_REG_WR[7:3]) reg_mem[c[2:0]] = w;
    if (o == OP_RD) resp = (c[7:3] == CMD_REG_RD[7:3]) ? reg_mem[c[2:0]] : 8'($urandom);
    if (o == OP_RD && answer) model_rdata = resp;
    e.err   = (o == OP_RSV) || (o == OP_RD && !answer);
    e.rdata = model_rdata;
    if (o != OP_RSV) tx_q.push_back(c);
    if (o == OP_WR)  tx_q.push_back(w);
    done_q.push_back(e);

    @(negedge sys_clk);
    check("busy low before start", busy, 0);
    start = 1'b1;
    op    = o;
    cmd   = c;
    wdata = w;
    @(negedge sys_clk);
    start = 1'b0;
    op    = 2'($urandom);
    cmd   = 8'($urandom);
    wdata = 8'($urandom);

    if (o == OP_RSV) begin
      check("op3 busy after start", busy, 1);
      check("op3 no early done", done, 0);
    end
    if (stray && (o == OP_CMD || o == OP_WR)) pulse_rx(8'hEE);
    if (o == OP_RD) begin
      wait_tx_fall();
      if (answer) begin
        repeat (GAP + 2 + $urandom_range(0, 8)) @(negedge sys_clk);
        rx_data  = resp;
        rx_valid = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
      end
    end
    wait_done(cyc);
    if (o == OP_RSV) check("op3 done latency", cyc, 1);
    if (o == OP_RD && !answer) begin
      check_range("timeout latency", cyc, TMO, TMO + GAP + 4);
      pulse_rx(8'hEE);  // late byte, must be dropped
    end
  endtask

  task automatic reset_mid_write();
    int dones = 0;
    bit ok    = 1'b0;
    tx_q.push_back(cmd_byte(CMD_REG_WR, 3'd3));
    tx_q.push_back(8'hA7);
    @(negedge sys_clk);
    start = 1'b1;
    op    = OP_WR;
    cmd   = cmd_byte(CMD_REG_WR, 3'd3);
    wdata = 8'hA7;
    @(negedge sys_clk);
    start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge sys_clk);
      if (tx_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("data byte reached before reset", ok, 1);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset rdata", rdata, 0);
    check("reset tx_start", tx_start, 0);
    model_rdata = 8'h00;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      if (done) dones++;
    end
    check("no done after reset abort", dones, 0);
  endtask

  function automatic logic [7:0] pick_cmd(input logic [1:0] o);
    logic [7:0] ctrl[4];
    logic [2:0] idx;
    ctrl[0] = CMD_CLK_HI;
    ctrl[1] = CMD_CLK_LO;
    ctrl[2] = CMD_RST_HI;
    ctrl[3] = CMD_RST_LO;
    idx = 3'($urandom);
    case (o)
      OP_WR:   return cmd_byte(($urandom_range(0, 2) != 0) ? CMD_REG_WR : CMD_PIN_WR, idx);
      OP_RD:   return cmd_byte(($urandom_range(0, 2) != 0) ? CMD_REG_RD : CMD_PIN_RD, idx);
      OP_CMD:  return ctrl[$urandom_range(0, 3)];
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    logic [1:0] o;
    bit         ans;
    for (int i = 0; i < 8; i++) reg_mem[i] = 8'hC1 + 8'(i);

    repeat (3) @(negedge sys_clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset rdata", rdata, 0);
    check("reset tx_start", tx_start, 0);
    check("reset tx_data", tx_data, 0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    issue(OP_WR, 8'h41, 8'h5A, 1'b1, 1'b0);        // write reg1 = 5A
    issue(OP_RD, 8'h52, 8'h00, 1'b1, 1'b0);        // read reg2 -> C3
    pulse_rx(8'hEE);                                // stray byte while idle
    issue(OP_CMD, CMD_CLK_HI, 8'h00, 1'b1, 1'b1);  // stray byte mid-op too
    issue(OP_RD, 8'h51, 8'h00, 1'b1, 1'b0);        // read back 5A
    issue(OP_RSV, 8'h99, 8'h00, 1'b1, 1'b0);
`ifdef UART_CMD_MASTER_TIMEOUT_EN
    issue(OP_RD, 8'h55, 8'h00, 1'b0, 1'b0);        // no answer -> timeout
    issue(OP_CMD, CMD_RST_LO, 8'h00, 1'b1, 1'b0);  // rdata still from last good read
`endif

    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom);
`ifdef UART_CMD_MASTER_TIMEOUT_EN
      ans = ($urandom_range(0, 4) != 0);
`else
      ans = 1'b1;
`endif
      issue(o, pick_cmd(o), 8'($urandom), ans, 1'($urandom));
    end

    reset_mid_write();
    issue(OP_WR, cmd_byte(CMD_REG_WR, 3'd3), 8'h3C, 1'b1, 1'b0);
    issue(OP_RD, cmd_byte(CMD_REG_RD, 3'd3), 8'h00, 1'b1, 1'b0);

    repeat (5) @(negedge sys_clk);
    check("done queue drained", done_q.size(), 0);
    check("tx queue drained", tx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: got run still active expected completion by 5 ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
